// File: rtl/compress_pkg.sv
// rtl/compress_pkg.sv - shared types, flags, code lengths and default widths for the instruction compressor/decompressor
package compress_pkg;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_TOKEN_W = 4;
    localparam int DEF_OUT_W   = 32;

    // Leading bit of every code: tells the decompressor whether a token or a raw word follows.
    localparam logic HIT_FLAG  = 1'b1;
    localparam logic MISS_FLAG = 1'b0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic int hit_code_len(input int token_w);
        return 1 + token_w;
    endfunction

    function automatic int miss_code_len(input int instr_w);
        return 1 + instr_w;
    endfunction

endpackage

// File: rtl/token_cam.sv
// rtl/token_cam.sv - combinational priority match of a key against the token table
//
// Ports:
//   tbl_i  - table contents, one INSTR_W entry per token index
//   vld_i  - per-entry valid bits; invalid entries never match
//   key_i  - instruction being looked up
//   hit_o  - at least one valid entry equals key_i
//   idx_o  - lowest matching index (0 when no hit)
module token_cam #(
    parameter int INSTR_W = 32,
    parameter int TOKEN_W = 4
) (
    input  logic [(2**TOKEN_W)-1:0][INSTR_W-1:0] tbl_i,
    input  logic [(2**TOKEN_W)-1:0]              vld_i,
    input  logic [INSTR_W-1:0]                   key_i,
    output logic                                 hit_o,
    output logic [TOKEN_W-1:0]                   idx_o
);

    localparam int ENTRIES = 2**TOKEN_W;

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vld_i[i] && (tbl_i[i] == key_i)) begin
                hit_o = 1'b1;
                idx_o = TOKEN_W'(i);
            end
        end
    end

endmodule

// File: rtl/instr_compressor.sv
// rtl/instr_compressor.sv - token-table instruction compressor packing variable-length codes into OUT_W words
//
// Optional feature: define INSTR_COMPRESSOR_STATS_EN to add hit_cnt/miss_cnt outputs.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   tbl_we/addr/data      - token-table write port (entry becomes valid, live next cycle)
//   in_valid/ready/instr/last   - instruction stream in
//   out_valid/ready/word/last   - packed code stream out, MSB-first, final word zero-padded
//   hit_cnt, miss_cnt     - saturating per-instruction counters (STATS_EN only)
module instr_compressor
    import compress_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int TOKEN_W = DEF_TOKEN_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tbl_we,
    input  logic [TOKEN_W-1:0] tbl_addr,
    input  logic [INSTR_W-1:0] tbl_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_word,
    output logic               out_last
`ifdef INSTR_COMPRESSOR_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);

    localparam int ENTRIES = 2**TOKEN_W;
    localparam int ACC_W   = 2 * OUT_W;
    localparam int CNT_W   = $clog2(ACC_W + 1);

    localparam logic [CNT_W-1:0] OUT_W_C  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] ACC_W_C  = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] HIT_LEN  = CNT_W'(hit_code_len(TOKEN_W));
    localparam logic [CNT_W-1:0] MISS_LEN = CNT_W'(miss_code_len(INSTR_W));

    state_e                          state_q, state_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ENTRIES-1:0][INSTR_W-1:0] tbl_q;
    logic [ENTRIES-1:0]              vld_q;

    logic               cam_hit;
    logic [TOKEN_W-1:0] cam_idx;
    logic [ACC_W-1:0]   code_ext;
    logic [CNT_W-1:0]   code_len;
    logic               in_fire;
    logic               out_fire;

    // Lookup sees the registered table, so a same-cycle write only affects later lookups.
    token_cam #(
        .INSTR_W(INSTR_W),
        .TOKEN_W(TOKEN_W)
    ) u_cam (
        .tbl_i(tbl_q),
        .vld_i(vld_q),
        .key_i(in_instr),
        .hit_o(cam_hit),
        .idx_o(cam_idx)
    );

    // Gated by reset so the input is refused for the whole reset pulse.
    assign in_ready  = !reset && (state_q == RUN) && (cnt_q < OUT_W_C);
    assign out_valid = (cnt_q >= OUT_W_C) || ((state_q == FLUSH) && (cnt_q != '0));
    // A flush word is the last one once nothing remains beyond it (covers exact multiples).
    assign out_last  = (state_q == FLUSH) && (cnt_q != '0) && (cnt_q <= OUT_W_C);
    assign out_word  = acc_q[ACC_W-1 -: OUT_W];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Code right-justified in an accumulator-wide vector.
    always_comb begin
        code_ext = '0;
        if (cam_hit) begin
            code_len             = HIT_LEN;
            code_ext[TOKEN_W:0]  = {HIT_FLAG, cam_idx};
        end else begin
            code_len             = MISS_LEN;
            code_ext[INSTR_W:0]  = {MISS_FLAG, in_instr};
        end
    end

    // Drain first, then append the new code directly below the bits still held.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (out_fire) begin
            acc_d = acc_q << OUT_W;
            cnt_d = (cnt_q >= OUT_W_C) ? (cnt_q - OUT_W_C) : '0;
            if (out_last) begin
                state_d = RUN;
            end
        end
        if (in_fire) begin
            acc_d = acc_d | ((code_ext << (ACC_W_C - code_len)) >> cnt_d);
            cnt_d = cnt_d + code_len;
            if (in_last) begin
                state_d = FLUSH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (tbl_we) begin
                tbl_q[tbl_addr] <= tbl_data;
                vld_q[tbl_addr] <= 1'b1;
            end
        end
    end

`ifdef INSTR_COMPRESSOR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (in_fire) begin
            if (cam_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else if (miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_compressor.sv
// tb/tb_instr_compressor.sv - directed self-checking bench for instr_compressor
module tb_instr_compressor;

    logic        clk;
    logic        reset;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
`ifdef INSTR_COMPRESSOR_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    instr_compressor dut (
        .clk      (clk),
        .reset    (reset),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_last (out_last)
`ifdef INSTR_COMPRESSOR_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic tbl_write(input logic [3:0] a, input logic [31:0] d);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_data = d;
        tick();
        tbl_we   = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] instr, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic l);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_word"}, 64'(out_word), 64'(w));
        check_eq({tag, "_last"}, 64'(out_last), 64'(l));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_data  = '0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;

        // Single hit: code 1_0011 padded to one last word.
        do_reset();
        tbl_write(4'd3, 32'hE12FFF1E);
        check_eq("t32_idle_valid", 64'(out_valid), 64'd0);
        send("t32", 32'hE12FFF1E, 1'b1);
        expect_word("t32", 32'h98000000, 1'b1);
        check_eq("t32_done_valid", 64'(out_valid), 64'd0);
        check_eq("t32_back_run", 64'(in_ready), 64'd1);

        // Single miss: 33-bit code spills into a second, last word.
        do_reset();
        send("t33", 32'hDEADBEEF, 1'b1);
        expect_word("t33a", 32'h6F56DF77, 1'b0);
        expect_word("t33b", 32'h80000000, 1'b1);
        check_eq("t33_done_valid", 64'(out_valid), 64'd0);
`ifdef INSTR_COMPRESSOR_STATS_EN
        check_eq("t33_miss_cnt", 64'(miss_cnt), 64'd1);
        check_eq("t33_hit_cnt", 64'(hit_cnt), 64'd0);
`endif

        // Duplicate entries: lowest index (2) wins.
        do_reset();
        tbl_write(4'd5, 32'h1EFF2FE1);
        tbl_write(4'd2, 32'h1EFF2FE1);
        send("t34", 32'h1EFF2FE1, 1'b1);
        expect_word("t34", 32'h90000000, 1'b1);

        // Seven hits fill 35 bits with output stalled.
        do_reset();
        tbl_write(4'd3, 32'hE12FFF1E);
        for (int i = 0; i < 7; i++) begin
            send("t35_fill", 32'hE12FFF1E, 1'b0);
        end
        in_valid = 1'b1;
        in_instr = 32'hE12FFF1E;
        for (int i = 0; i < 3; i++) begin
            check_eq("t35_stall_in_ready", 64'(in_ready), 64'd0);
            check_eq("t35_stall_valid", 64'(out_valid), 64'd1);
            check_eq("t35_stall_word", 64'(out_word), 64'h9CE739CE);
            tick();
        end
        in_valid = 1'b0;
        expect_word("t35a", 32'h9CE739CE, 1'b0);
        send("t35_tail", 32'hE12FFF1E, 1'b1);
        expect_word("t35b", 32'h73000000, 1'b1);
`ifdef INSTR_COMPRESSOR_STATS_EN
        check_eq("t35_hit_cnt", 64'(hit_cnt), 64'd8);
`endif

        // Table write coincident with lookup: old contents -> miss; next lookup hits.
        do_reset();
        tbl_we   = 1'b1;
        tbl_addr = 4'd1;
        tbl_data = 32'h12345678;
        in_valid = 1'b1;
        in_instr = 32'h12345678;
        in_last  = 1'b0;
        check_eq("t36_in_ready", 64'(in_ready), 64'd1);
        tick();
        tbl_we   = 1'b0;
        in_valid = 1'b0;
        expect_word("t36a", 32'h091A2B3C, 1'b0);
        send("t36", 32'h12345678, 1'b1);
        expect_word("t36b", 32'h44000000, 1'b1);

        // Flush that ends exactly on a word boundary: 2 misses + 6 hits = 96 bits.
        do_reset();
        tbl_write(4'd0, 32'h00000001);
        send("tx_m0", 32'h00000000, 1'b0);
        expect_word("tx_w0", 32'h00000000, 1'b0);
        send("tx_m1", 32'h00000000, 1'b0);
        expect_word("tx_w1", 32'h00000000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send("tx_h", 32'h00000001, (i == 5));
        end
        expect_word("tx_w2", 32'h21084210, 1'b1);
        check_eq("tx_done_valid", 64'(out_valid), 64'd0);

        // Reset mid-flush discards everything at once.
        do_reset();
        send("t37", 32'hDEADBEEF, 1'b1);
        check_eq("t37_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t37_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t37_rst_last", 64'(out_last), 64'd0);
        check_eq("t37_rst_in_ready", 64'(in_ready), 64'd0);
`ifdef INSTR_COMPRESSOR_STATS_EN
        check_eq("t37_hit_cnt", 64'(hit_cnt), 64'd0);
        check_eq("t37_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
        tick();
        reset = 1'b0;
        #1;
        check_eq("t37_after_in_ready", 64'(in_ready), 64'd1);
        tick();
        check_eq("t37_after_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_compressor.md
INSTR_COMPRESSOR -- requirements
Module: instr_compressor

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, meaning the width of an uncompressed instruction.
REQ-002 SHALL have parameter TOKEN_W, default 4, meaning the token index width; the table holds 2**TOKEN_W entries.
REQ-003 SHALL have parameter OUT_W, default 32, meaning the width of a packed output word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports tbl_we (in, 1), tbl_addr (in, TOKEN_W) and tbl_data (in, INSTR_W): the token-table write port.
REQ-007 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_instr (in, INSTR_W) and in_last (in, 1): the instruction stream input.
REQ-008 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_word (out, OUT_W) and out_last (out, 1): the compressed stream output.

Function
REQ-009 SHALL form the code for an accepted instruction as follows.
- Hit: 1'b1 followed by the token index (1+TOKEN_W bits).
- Miss: 1'b0 followed by the raw instruction (1+INSTR_W bits).
REQ-010 SHALL look up only entries whose valid bit is set; if several entries match, the lowest index wins.
REQ-011 SHALL append codes MSB-first into a 2*OUT_W-bit accumulator, so the first code starts at out_word[OUT_W-1].
REQ-012 SHALL accept an input word only when in_valid && in_ready.
REQ-013 SHALL drive in_ready = (state==RUN) && (acc_count < OUT_W).
REQ-014 SHALL drive out_valid = (acc_count >= OUT_W) or (state==FLUSH && acc_count > 0).
REQ-015 SHALL present out_word = acc[2*OUT_W-1:OUT_W] (the top OUT_W bits of the accumulator).
REQ-016 SHALL, on an output handshake, shift the accumulator left by OUT_W and reduce acc_count by min(OUT_W, acc_count).
REQ-017 SHALL support a same-cycle input and output handshake, with acc_count' = acc_count + code_len - OUT_W.
REQ-018 SHALL make a code accepted in cycle N visible in the accumulator at N+1; out_valid is asserted no earlier than N+1.
REQ-019 SHALL hold out_word and out_last stable while out_valid && !out_ready.
REQ-020 SHALL implement the FSM states RUN and FLUSH with these transitions.
- RUN -> FLUSH when an accepted word has in_last=1.
- FLUSH -> RUN after the handshake on the word carrying out_last.
REQ-021 SHALL, in FLUSH, emit the final partial word zero-padded in its LSBs.
REQ-022 SHALL assert out_last only on the last word of the flush, including the case where acc_count is an exact multiple of OUT_W.
REQ-023 SHALL apply a table write in the same cycle as a lookup only after the lookup; that lookup uses the old contents.
REQ-024 SHALL set an entry's valid bit when it is written; the entry is live from the next cycle.

Reset
REQ-025 SHALL, while reset is high, drive: state=RUN, acc=0, acc_count=0, all table valid bits=0, out_valid=0, out_last=0, in_ready=0.
REQ-026 SHALL, on reset asserted mid-stream or mid-flush, discard all pending bits immediately; no partial word is emitted.
REQ-027 SHALL assert in_ready in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL, with macro INSTR_COMPRESSOR_STATS_EN defined, provide outputs hit_cnt and miss_cnt.
- Each is 16 bits, reset to 0, saturating at 16'hFFFF.
- Incremented once per accepted instruction.
REQ-029 SHALL, without INSTR_COMPRESSOR_STATS_EN, omit those ports and their counters entirely.

Structure
REQ-030 SHALL place the following in a shared package compress_pkg, also used by the decompressor:
- the state enum;
- HIT_FLAG/MISS_FLAG;
- the code-length functions;
- default widths.
REQ-031 SHALL implement the lookup as a purely combinational sub-module token_cam (table, valid bits, priority match), outputting hit and idx.

Verification
REQ-032 SHALL cover: table[3]=32'hE12FFF1E; send 32'hE12FFF1E with last -> one word 32'h98000000 with out_last=1.
REQ-033 SHALL cover: empty table; send 32'hDEADBEEF with last -> 32'h6F56DF77 then 32'h80000000 with out_last=1.
REQ-034 SHALL cover: table[2]=table[5]=32'h1EFF2FE1; send that value -> code 1_0010.
REQ-035 SHALL cover: seven hits (35 bits), out_ready=0 -> in_ready=0 once acc_count>=32 and out_word held stable; release -> stream completes correctly.
REQ-036 SHALL cover: table write to entry 1 in the same cycle as a lookup of its new value -> miss; a repeat lookup next cycle -> hit.
REQ-037 SHALL cover: reset pulse during FLUSH -> out_valid=0 immediately, no out_last; with STATS_EN, hit_cnt=miss_cnt=0.
